// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and the digit type, used by the BCD up and down counters.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the BCD down counter: synchronous load (clamped to BCD), decrement with 0 -> 9 roll.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load,
    input  logic [3:0] LoadDigit,
    input  logic       Dec,
    output logic [3:0] Q,
    output logic       IsZero
);

    // Any nibble above 9 saturates so the register can never hold a non-BCD code.
    function automatic bcd_t bcd_clamp(input logic [3:0] d);
        bcd_clamp = (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= BCD_ZERO;
        end else if (Load) begin
            Q <= bcd_clamp(LoadDigit);
        end else if (Dec) begin
            Q <= (Q == BCD_ZERO) ? BCD_MAX : Q - 4'd1;
        end
    end

    assign IsZero = (Q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// Three-digit BCD down timer: per-digit registers, same-edge borrow chain, optional wrap at 000,
// and a registered one-cycle Done pulse on arrival at 000 by decrement.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Load,
    input  logic [11:0] LoadVal,
    input  logic        Enable,
    output logic [3:0]  Q1,
    output logic [3:0]  Q10,
    output logic [3:0]  Q100,
    output logic        Zero,
    output logic        Done
);

    logic z1, z10, z100;
    logic dec1, dec10, dec100;
    logic at_one;

    assign Zero = z1 & z10 & z100;

    // At 000 the chain only fires when wrapping; every digit then borrows to give 999.
    assign dec1   = Enable & (~Zero | WRAP);
    assign dec10  = dec1 & z1;
    assign dec100 = dec10 & z10;

    assign at_one = z100 & z10 & (Q1 == 4'd1);

    bcd_down_digit u_ones (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (Load),
        .LoadDigit (LoadVal[3:0]),
        .Dec       (dec1),
        .Q         (Q1),
        .IsZero    (z1)
    );

    bcd_down_digit u_tens (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (Load),
        .LoadDigit (LoadVal[7:4]),
        .Dec       (dec10),
        .Q         (Q10),
        .IsZero    (z10)
    );

    bcd_down_digit u_hundreds (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (Load),
        .LoadDigit (LoadVal[11:8]),
        .Dec       (dec100),
        .Q         (Q100),
        .IsZero    (z100)
    );

    // Done rises together with the 001 -> 000 step; a Load in the same cycle suppresses it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Done <= 1'b0;
        end else begin
            Done <= ~Load & Enable & at_one;
        end
    end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter WRAP, default 0, meaning: 0 = hold at 000 when decremented at zero, 1 = wrap 000 -> 999.
REQ-002 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Load  input  1  when high, LoadVal is captured into the digit registers.
REQ-005 LoadVal  input  12  load value as three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 Enable  input  1  decrement request, one count per cycle while high.
REQ-007 Q1  output  4  ones digit, BCD.
REQ-008 Q10  output  4  tens digit, BCD.
REQ-009 Q100  output  4  hundreds digit, BCD.
REQ-010 Zero  output  1  high while Q100:Q10:Q1 == 000.
REQ-011 Done  output  1  one-cycle pulse marking arrival at 000 by decrement.

Function
REQ-012 Per-edge priority SHALL be: Reset > Load > Enable decrement > hold.
REQ-013 Load SHALL update all three digits at the sampling edge, so new values are visible the next cycle.
REQ-014 A LoadVal digit above 9 SHALL be clamped to 9, independently per digit; outputs SHALL never hold a non-BCD value.
REQ-015 Load SHALL never assert Done, including a load of 000.
REQ-016 Enable high with count != 000: ones digit SHALL decrement; 0 -> 9 SHALL borrow.
REQ-017 Borrow SHALL be combinational within the same edge: tens decrements iff Enable & Q1==0; hundreds iff Enable & Q1==0 & Q10==0; each borrowing digit 0 -> 9.
REQ-018 Enable high with count == 000, WRAP=0: count SHALL hold at 000, and Done SHALL stay low.
REQ-019 Enable high with count == 000, WRAP=1: count SHALL become 999, and Done SHALL stay low.
REQ-020 Enable low and Load low: all digits SHALL hold.
REQ-021 Zero SHALL be a pure decode of the digit registers, with zero latency relative to Q outputs.
REQ-022 Done SHALL be registered and high for exactly the one cycle in which outputs first show 000 after a 001 -> 000 decrement.
REQ-023 Done SHALL be low in every other cycle, including while 000 is held.
REQ-024 Load and Enable high together: Load wins, with no decrement applied to the loaded value.
REQ-025 Latency from Enable or Load sampled to Q change SHALL be exactly one edge, with no pipeline stages.

Reset
REQ-026 Reset high at an edge SHALL set Q1=Q10=Q100=0, Done=0; Zero consequently reads 1.
REQ-027 Load and Enable SHALL be ignored in any cycle where Reset is high.
REQ-028 Reset mid-count SHALL abort the count; counting resumes from 000 only after a Load.
REQ-029 No asynchronous reset path SHALL exist.

Structure
REQ-030 Shared package bcd_pkg SHALL hold BCD_MAX (4'd9) and BCD_ZERO (4'd0), for use by the up-counter and this block.
REQ-031 One sub-module bcd_down_digit SHALL be instantiated three times.
REQ-032 bcd_down_digit ports SHALL be: Clock, Reset, Load, LoadDigit[3:0], Dec, Q[3:0], IsZero.
REQ-033 The top level SHALL hold the borrow chain, WRAP handling and the Done register.

Verification
REQ-034 Reset, then Load 123, then Enable 123 cycles -> Done pulses exactly once, with Q=000 in that cycle; Zero stays 1 afterwards.
REQ-035 Load 100, Enable 1 cycle -> Q=099; one more cycle -> Q=098.
REQ-036 Load 000 -> Done stays 0. Enable 5 cycles with WRAP=0 -> Q stays 000 and Done stays 0. With WRAP=1, Enable 1 cycle -> Q=999 and Done=0.
REQ-037 Load 0xAF5 -> Q100=9, Q10=9, Q1=5.
REQ-038 Load 050 with Enable high in the same cycle -> Q=050 next cycle, not 049.
REQ-039 At Q=037 with Enable high, assert Reset for 1 cycle -> Q=000, Done=0. With Load high during that Reset cycle -> load ignored.
